// File: rtl/noc_ack_gen.sv
// Bus-side acknowledge controller feeding the NoC ready generator with fresh 1..15 tags.
// Define NOC_ACKGEN_TIMEOUT_EN to build the WAIT timeout counter and the ERR state.
module noc_ack_gen #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ce_i,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic       sel_i,
  output logic       ack_o,
  output logic       err_o,
  output logic       busy_o,
  output logic       req_o,
  output logic [3:0] tid_o,
  input  logic       rdy_i,
  input  logic [3:0] rid_i
);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("noc_ack_gen: TIMEOUT must be within 2..65535");
  end

  typedef enum logic [1:0] {StIdle, StWait, StAck, StErr} state_e;

  state_e     state_q, state_d;
  logic       ack_q, ack_d;
  logic       req_q, req_d;
  logic [3:0] tid_q, tid_d;
  logic [3:0] ntag_q, ntag_d;

  logic bus_live;
  logic bus_req;
  logic rdy_match;

  assign bus_live  = cyc_i & stb_i;
  assign bus_req   = bus_live & sel_i;
  assign rdy_match = rdy_i & (rid_i == tid_q);

`ifdef NOC_ACKGEN_TIMEOUT_EN
  localparam int unsigned    CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    req_d   = req_q;
    tid_d   = tid_q;
    ntag_d  = ntag_q;
`ifdef NOC_ACKGEN_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    if (ce_i) begin
      case (state_q)
        StIdle: begin
          if (bus_req) begin
            state_d = StWait;
            req_d   = 1'b1;
            tid_d   = ntag_q;
            // Tag 0 is reserved: the generator reports 0 while idle.
            ntag_d  = (ntag_q == 4'd15) ? 4'd1 : ntag_q + 4'd1;
`ifdef NOC_ACKGEN_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
        StWait: begin
          if (!bus_live) begin
            state_d = StIdle;
            req_d   = 1'b0;
          end else if (rdy_match) begin
            state_d = StAck;
            ack_d   = 1'b1;
`ifdef NOC_ACKGEN_TIMEOUT_EN
          end else if (cnt_q == CntLast) begin
            state_d = StErr;
            err_d   = 1'b1;
            req_d   = 1'b0;
          end else begin
            cnt_d   = cnt_q + CntW'(1);
`endif
          end
        end
        StAck: begin
          if (!stb_i) begin
            state_d = StIdle;
            ack_d   = 1'b0;
            req_d   = 1'b0;
          end
        end
`ifdef NOC_ACKGEN_TIMEOUT_EN
        StErr: begin
          if (!stb_i) begin
            state_d = StIdle;
            err_d   = 1'b0;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
      req_q   <= 1'b0;
      tid_q   <= 4'd0;
      ntag_q  <= 4'd1;
`ifdef NOC_ACKGEN_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      req_q   <= req_d;
      tid_q   <= tid_d;
      ntag_q  <= ntag_d;
`ifdef NOC_ACKGEN_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign ack_o  = ack_q;
  assign req_o  = req_q;
  assign tid_o  = tid_q;
  assign busy_o = (state_q != StIdle);
`ifdef NOC_ACKGEN_TIMEOUT_EN
  assign err_o  = err_q;
`else
  assign err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_noc_ack_gen.sv
// Self-checking bench for noc_ack_gen: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model and a 3-stage generator stand-in.
module tb_noc_ack_gen;

  localparam int unsigned TIMEOUT = 8;
`ifdef NOC_ACKGEN_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif
  localparam int Waiting = 0;
  localparam int Acked   = 1;
  localparam int Errored = 2;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       ce_i  = 1'b1;
  logic       cyc_i = 1'b0;
  logic       stb_i = 1'b0;
  logic       sel_i = 1'b0;
  logic       ack_o, err_o, busy_o, req_o;
  logic [3:0] tid_o;
  logic       rdy_i;
  logic [3:0] rid_i;

  logic       gen_auto = 1'b1;
  logic       man_rdy  = 1'b0;
  logic [3:0] man_rid  = 4'd0;
  logic [3:0] rid_mask = 4'd0;

  int n_chk  = 0;
  int n_pass = 0;

  noc_ack_gen #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .ce_i   (ce_i),
    .cyc_i  (cyc_i),
    .stb_i  (stb_i),
    .sel_i  (sel_i),
    .ack_o  (ack_o),
    .err_o  (err_o),
    .busy_o (busy_o),
    .req_o  (req_o),
    .tid_o  (tid_o),
    .rdy_i  (rdy_i),
    .rid_i  (rid_i)
  );

  always #5 clk_i = ~clk_i;

  // Ready generator stand-in with STAGES=3: request seen after e0 appears as ready after e0+4.
  logic [3:0] pv;
  logic [3:0] pt0, pt1, pt2, pt3;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pv  <= '0;
      pt0 <= '0;
      pt1 <= '0;
      pt2 <= '0;
      pt3 <= '0;
    end else if (ce_i) begin
      pv  <= {pv[2:0], req_o};
      pt0 <= tid_o;
      pt1 <= pt0;
      pt2 <= pt1;
      pt3 <= pt2;
    end
  end
  assign rdy_i = gen_auto ? pv[3] : man_rdy;
  assign rid_i = gen_auto ? ((pv[3] ? pt3 : 4'd0) ^ rid_mask) : man_rid;

  // Transaction-level model: is a bus transaction open, how did it finish, how long has it waited.
  logic m_open;
  int   m_done, m_age, m_tag, m_next;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_open <= 1'b0;
      m_done <= Waiting;
      m_age  <= 0;
      m_tag  <= 0;
      m_next <= 1;
    end else if (ce_i) begin
      if (!m_open) begin
        if (cyc_i && stb_i && sel_i) begin
          m_open <= 1'b1;
          m_done <= Waiting;
          m_age  <= 0;
          m_tag  <= m_next;
          m_next <= (m_next % 15) + 1;
        end
      end else if (m_done == Waiting) begin
        if (!(cyc_i && stb_i)) m_open <= 1'b0;
        else if (rdy_i && int'(rid_i) == m_tag) m_done <= Acked;
        else if (ToEn && m_age + 1 == int'(TIMEOUT)) m_done <= Errored;
        else m_age <= m_age + 1;
      end else if (!stb_i) begin
        m_open <= 1'b0;
        m_done <= Waiting;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        check("m_ack",  ack_o,  int'(m_open && m_done == Acked));
        check("m_err",  err_o,  int'(m_open && m_done == Errored));
        check("m_req",  req_o,  int'(m_open && m_done != Errored));
        check("m_busy", busy_o, int'(m_open));
        check("m_tid",  tid_o,  m_tag);
        check("m_excl", int'(ack_o & err_o), 0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic bus(input logic c, input logic s, input logic l);
    cyc_i = c;
    stb_i = s;
    sel_i = l;
  endtask

  task automatic rst_pulse();
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
  endtask

  task automatic wait_ack(input int max);
    int n = 0;
    while (!ack_o && n < max) begin
      tick();
      n++;
    end
    check("ack_seen", ack_o, 1);
  endtask

  initial begin
    fork
      compare_loop();
    join_none

    // Reset values
    repeat (3) tick();
    check("rst_ack", ack_o, 0);
    check("rst_err", err_o, 0);
    check("rst_req", req_o, 0);
    check("rst_tid", tid_o, 0);
    check("rst_busy", busy_o, 0);
    rst_i = 1'b0;

    // Single read, S=3
    bus(1, 1, 1);
    tick();
    check("t1_req", req_o, 1);
    check("t1_tid", tid_o, 1);
    repeat (4) tick();
    check("t1_ack_early", ack_o, 0);
    tick();
    check("t1_ack", ack_o, 1);
    bus(0, 0, 0);
    tick();
    check("t1_ack_fall", ack_o, 0);
    check("t1_req_fall", req_o, 0);

    // 16 transactions: tags 1..15 then 1
    rst_pulse();
    for (int k = 0; k < 16; k++) begin
      bus(1, 1, 1);
      tick();
      check("t2_tid", tid_o, (k % 15) + 1);
      check("t2_tid_nz", int'(tid_o != 4'd0), 1);
      wait_ack(20);
      bus(0, 0, 0);
      tick();
      check("t2_gap_req", req_o, 0);
    end

    // Mismatching tag ignored; tag 2 aborted so next is 3
    gen_auto = 1'b0;
    man_rdy  = 1'b0;
    bus(1, 1, 1);
    tick();
    bus(0, 0, 0);
    tick();
    bus(1, 1, 1);
    tick();
    check("t3_tid", tid_o, 3);
    man_rdy = 1'b1;
    man_rid = 4'd7;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_nomatch", ack_o, 0);
    end
    man_rid = 4'd3;
    tick();
    check("t3_ack", ack_o, 1);
    man_rdy = 1'b0;
    bus(0, 0, 0);
    tick();
    check("t3_ack_fall", ack_o, 0);

    // Abort beats same-edge matching ready (tag 4)
    bus(1, 1, 1);
    tick();
    tick();
    bus(0, 0, 0);
    man_rdy = 1'b1;
    man_rid = 4'd4;
    tick();
    check("t4_ack", ack_o, 0);
    check("t4_req", req_o, 0);
    check("t4_busy", busy_o, 0);
    man_rdy = 1'b0;

    // Timeout with ready stuck low (tag 5)
    bus(1, 1, 1);
    tick();
`ifdef NOC_ACKGEN_TIMEOUT_EN
    repeat (7) tick();
    check("t5_err_early", err_o, 0);
    tick();
    check("t5_err", err_o, 1);
    check("t5_req", req_o, 0);
    repeat (3) tick();
    check("t5_err_hold", err_o, 1);
    bus(0, 0, 0);
    tick();
    check("t5_err_fall", err_o, 0);
    check("t5_busy", busy_o, 0);
`else
    repeat (1000) tick();
    check("t5_no_err", err_o, 0);
    check("t5_busy_wait", busy_o, 1);
    bus(0, 0, 0);
    tick();
    check("t5_busy", busy_o, 0);
`endif

    // ce_i low for 4 edges delays the ack by 4 (tag 6)
    gen_auto = 1'b1;
    bus(1, 1, 1);
    tick();
    tick();
    ce_i = 1'b0;
    repeat (4) tick();
    ce_i = 1'b1;
    repeat (3) tick();
    check("t6_ack_early", ack_o, 0);
    tick();
    check("t6_ack", ack_o, 1);

    // Reset in ACK clears everything immediately
    tick();
    rst_i = 1'b1;
    #1;
    check("t7_ack", ack_o, 0);
    check("t7_req", req_o, 0);
    check("t7_tid", tid_o, 0);
    check("t7_busy", busy_o, 0);
    check("t7_err", err_o, 0);
    #1;
    rst_i = 1'b0;
    bus(0, 0, 0);
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic sticky;
      sticky   = ((c / 64) % 2) == 1;
      gen_auto = ((c / 128) % 2) == 0;
      ce_i     = ($urandom % 8) != 0;
      cyc_i    = sticky ? (($urandom % 32) != 0) : (($urandom % 8) != 0);
      stb_i    = sticky ? (($urandom % 32) != 0) : (($urandom % 4) != 0);
      sel_i    = ($urandom % 2) != 0;
      rid_mask = (($urandom % 6) == 0) ? 4'($urandom) : 4'd0;
      man_rdy  = ($urandom % 3) == 0;
      man_rid  = (($urandom % 2) != 0) ? 4'(m_tag) : 4'($urandom);
      tick();
    end

    ce_i     = 1'b1;
    rid_mask = 4'd0;
    bus(0, 0, 0);
    repeat (4) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
